wb_write_queue: RTL and testbench

- Writeback-side write buffer that feeds the register file's single write port (RegWrite/W/WData).
- Accepts register write requests from the WB stage and multi-cycle units over a valid/ready handshake and holds them in an in-order FIFO.
- Drains one entry per cycle when the write port is available.
- Provides a combinational pending-write lookup so decode-stage forwarding sees data not yet committed to the register file.

---
 rtl/wb_write_queue.sv | 151 +++++++++++++++
 tb/tb_wb_write_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write buffer in front of the register file's single
// write port. Requests are queued, drained one per cycle into a registered
// {RegWrite, W, WData} output, and every pending write (queued or in the output
// register) is visible to decode through a combinational forwarding lookup.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  // Request handshake: a request transfers on a rising edge where in_valid
  // and in_ready are both high; in_ready depends only on occupancy, never on
  // in_valid, so the producer may hold in_valid until it sees in_ready.
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_reg,
  input  logic [31:0]   in_data,
  input  logic          drain_en,
  output logic          RegWrite,
  output logic [4:0]    W,
  output logic [31:0]   WData,
  input  logic [4:0]    R1,
  input  logic [4:0]    R2,
  output logic          hit1,
  output logic          hit2,
  output logic [31:0]   fwd1,
  output logic [31:0]   fwd2,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]    ent_reg_q  [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          regwrite_q, regwrite_d;
  logic [4:0]    w_q, w_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          accept;
  logic          push;
  logic          pop;
  logic [AW-1:0] idx;

  // A full queue refuses requests even if it drains this cycle, keeping
  // in_ready a pure function of registered state.
  assign in_ready = (count_q != FULL);
  assign accept   = in_valid && in_ready;
  // Writes to r0 complete the handshake but are dropped: r0 is never written.
  assign push     = accept && (in_reg != 5'd0);
  assign pop      = drain_en && (count_q != '0);

  // Next-state for pointers, occupancy and the registered write port.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    regwrite_d = 1'b0;
    w_d        = w_q;
    wdata_d    = wdata_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      regwrite_d = 1'b1;
      w_d        = ent_reg_q[rd_ptr_q];
      wdata_d    = ent_data_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state and output register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      w_q        <= '0;
      wdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      w_q        <= w_d;
      wdata_q    <= wdata_d;
    end
  end

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg_q[wr_ptr_q]  <= in_reg;
      ent_data_q[wr_ptr_q] <= in_data;
    end
  end

  // Forwarding lookup: scan oldest to newest so the youngest match overrides;
  // the output register (if still strobing) is the oldest candidate of all.
  always_comb begin
    hit1 = 1'b0;
    fwd1 = '0;
    hit2 = 1'b0;
    fwd2 = '0;
    idx  = '0;
    if (regwrite_q && (w_q == R1)) begin
      hit1 = 1'b1;
      fwd1 = wdata_q;
    end
    if (regwrite_q && (w_q == R2)) begin
      hit2 = 1'b1;
      fwd2 = wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if ((AW+1)'(i) < count_q) begin
        if (ent_reg_q[idx] == R1) begin
          hit1 = 1'b1;
          fwd1 = ent_data_q[idx];
        end
        if (ent_reg_q[idx] == R2) begin
          hit2 = 1'b1;
          fwd2 = ent_data_q[idx];
        end
      end
    end
    if (R1 == 5'd0) begin
      hit1 = 1'b0;
      fwd1 = '0;
    end
    if (R2 == 5'd0) begin
      hit2 = 1'b0;
      fwd2 = '0;
    end
  end

  assign RegWrite = regwrite_q;
  assign W        = w_q;
  assign WData    = wdata_q;
  assign count    = count_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed vectors with hand-computed expectations,
// a commit scoreboard fed at issue time and drained by a negedge monitor.
module tb_wb_write_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        drain_en;
  logic        RegWrite;
  logic [4:0]  W;
  logic [31:0] WData;
  logic [4:0]  R1;
  logic [4:0]  R2;
  logic        hit1;
  logic        hit2;
  logic [31:0] fwd1;
  logic [31:0] fwd2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  wb_write_queue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .drain_en(drain_en),
    .RegWrite(RegWrite), .W(W), .WData(WData),
    .R1(R1), .R2(R2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [4:0] r, input logic [31:0] d, input bit expect_commit);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    if (expect_commit) exp_q.push_back({r, d});
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected commit
  always @(negedge clk) begin
    if (!rst && RegWrite) begin
      if (exp_q.size() == 0) begin
        check("commit_unexpected", {1'b1, W, WData}, 37'd0);
      end else begin
        check("commit", {W, WData}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
    drain_en = 1'b0; R1 = '0; R2 = '0;
    #2;
    check("reset_in_ready", in_ready, 1);
    check("reset_count", count, 0);
    check("reset_regwrite", RegWrite, 0);
    check("reset_w_wdata", {W, WData}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single write: enqueue at edge 1, dequeue at edge 2
    drain_en = 1'b1;
    drive_req(5'd8, 32'd9, 1'b1);
    check("single_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("single_count_e1", count, 1);
    check("single_rw_e1", RegWrite, 0);
    tick();
    check("single_rw_e2", RegWrite, 1);
    check("single_w_e2", {W, WData}, {5'd8, 32'd9});
    check("single_count_e2", count, 0);
    tick();
    check("single_rw_e3", RegWrite, 0);
    check("single_count_e3", count, 0);

    // Fill to full, hold off fifth request, then drain in order
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(5'(9 + i), 32'(1 + i), 1'b1);
      tick();
    end
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    drive_req(5'd13, 32'd5, 1'b1);
    tick();
    check("held_off_count", count, 4);
    drain_en = 1'b1;
    check("full_ready_while_drain", in_ready, 0);
    tick();
    check("drain0_w", {RegWrite, W}, {1'b1, 5'd9});
    check("drain0_count", count, 3);
    check("drain0_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("drain1_w", {RegWrite, W}, {1'b1, 5'd10});
    check("drain1_count_fifth_accepted", count, 3);
    tick();
    check("drain2_w", {RegWrite, W}, {1'b1, 5'd11});
    check("drain2_count", count, 2);
    tick();
    check("drain3_w", {RegWrite, W}, {1'b1, 5'd12});
    tick();
    check("drain4_w", {RegWrite, W, WData}, {1'b1, 5'd13, 32'd5});
    check("drain4_count", count, 0);
    tick();
    check("drain_done_rw", RegWrite, 0);

    // Lookup: youngest match wins, survives partial drain, output reg candidate
    drain_en = 1'b0;
    drive_req(5'd9, 32'd5, 1'b1);
    tick();
    drive_req(5'd9, 32'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    R1 = 5'd9;
    R2 = 5'd10;
    #1;
    check("lk_hit1", hit1, 1);
    check("lk_fwd1", fwd1, 7);
    check("lk_miss2", {hit2, fwd2}, 0);
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    check("lk_drain_w", {RegWrite, W, WData}, {1'b1, 5'd9, 32'd5});
    check("lk_after_drain", {hit1, fwd1}, {1'b1, 32'd7});
    tick();
    check("lk_stall", {RegWrite, hit1, fwd1}, {1'b0, 1'b1, 32'd7});
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    check("lk_outreg_count", count, 0);
    check("lk_outreg_hit", {hit1, fwd1}, {1'b1, 32'd7});
    tick();
    check("lk_gone", {hit1, fwd1}, 0);

    // r0 write: handshake completes, nothing stored
    drain_en = 1'b1;
    R1 = 5'd0;
    drive_req(5'd0, 32'hFFFF_FFFF, 1'b0);
    check("r0_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("r0_count", count, 0);
    check("r0_hit1", {hit1, fwd1}, 0);
    tick();
    check("r0_no_rw", RegWrite, 0);

    // Streaming with wrap
    for (int i = 0; i < 10; i++) begin
      drive_req(5'(8 + i), 32'(100 + i), 1'b1);
      tick();
      check("stream_count", count, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_last", {RegWrite, W, WData}, {1'b1, 5'd17, 32'd109});
    check("stream_empty", count, 0);
    tick();
    check("stream_rw_off", RegWrite, 0);

    // Mid-cycle asynchronous reset with count=3 and RegWrite=1
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(5'(20 + i), 32'(32 + i), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    R1 = 5'd22;
    R2 = 5'd23;
    #1;
    check("pre_rst_state", {RegWrite, W, count}, {1'b1, 5'd20, 3'd3});
    check("pre_rst_hit", {hit1, hit2}, 2'b11);
    rst = 1'b1;
    #1;
    check("async_rst_out", {RegWrite, W, WData}, 0);
    check("async_rst_count", count, 0);
    check("async_rst_hits", {hit1, hit2}, 0);
    check("async_rst_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_quiet", {RegWrite, count}, 0);
    end

    check("scoreboard_drained", 37'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
